// File: rtl/tea_pkg.sv
// Shared definitions for the TEA frame loader and the encrypt core.
//   state_t   : loader FSM states (CHK is only reachable when the
//               TEA_LOADER_CHECKSUM_EN macro is defined)
//   HDR_*     : default frame header bytes
//   KEY_BYTES : key payload length in bytes
//   BLK_BYTES : plaintext block payload length in bytes
//   DELTA     : TEA key schedule constant, shared with the encrypt core
package tea_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEY    = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHK    = 3'd3,
    ST_LAUNCH = 3'd4
  } state_t;

  localparam logic [7:0]  HDR_KEY_DEFAULT  = 8'hA5;
  localparam logic [7:0]  HDR_DATA_DEFAULT = 8'h5A;
  localparam int          KEY_BYTES        = 16;
  localparam int          BLK_BYTES        = 8;
  localparam logic [31:0] DELTA            = 32'h9E37_79B9;

endpackage

// File: rtl/tea_byte_shifter.sv
// MSB-first byte shift register with a wrapping byte counter.
// Ports:
//   clk     : clock
//   reset   : synchronous active-high, clears the byte counter only
//   i_load  : shift i_byte in at the LSB end and advance the counter
//   i_byte  : byte to shift in
//   o_data  : assembled NBYTES-byte word, first byte loaded in the MSBs
//   o_last  : counter points at the final byte of the word
module tea_byte_shifter #(
  parameter int NBYTES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic [7:0]            i_byte,
  output logic [NBYTES*8-1:0]   o_data,
  output logic                  o_last
);

  localparam int CNT_W = $clog2(NBYTES);

  logic [NBYTES*8-1:0] r_data;
  logic [CNT_W-1:0]    r_count;

  // Payload storage carries no reset; stale contents are never committed.
  always_ff @(posedge clk) begin
    if (i_load) r_data <= {r_data[NBYTES*8-9:0], i_byte};
  end

  // Counter wraps after the final byte so the next frame starts at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= o_last ? '0 : r_count + CNT_W'(1);
    end
  end

  assign o_data = r_data;
  assign o_last = (r_count == CNT_W'(NBYTES - 1));

endmodule

// File: rtl/tea_frame_loader.sv
// Byte-stream front end for the TEA encrypt core. Assembles a 128-bit key
// and a 64-bit plaintext block from framed bytes, then raises start and
// holds it until the core reports enc_done. The key persists across frames.
// Optional feature macro: TEA_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte (header ^ payload) that must match for the frame to commit.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   s_data/s_valid    : input byte stream
//   s_ready           : byte accepted when s_valid && s_ready
//   key               : {k0,k1,k2,k3}, k0 in [127:96]
//   v0, v1            : plaintext words
//   start             : held high from launch until enc_done is sampled
//   enc_done          : encrypt core completion
//   key_valid         : a key has been committed since reset
//   frame_err         : one-cycle pulse on a rejected frame
module tea_frame_loader
  import tea_pkg::*;
#(
  parameter logic [7:0] HDR_KEY  = HDR_KEY_DEFAULT,
  parameter logic [7:0] HDR_DATA = HDR_DATA_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [127:0] key,
  output logic [31:0]  v0,
  output logic [31:0]  v1,
  output logic         start,
  input  logic         enc_done,
  output logic         key_valid,
  output logic         frame_err
);

  state_t         r_state;
  logic           r_ready;
  logic           r_start;
  logic           r_key_valid;
  logic           r_frame_err;
  logic           r_is_key;
  logic [127:0]   r_key;
  logic [31:0]    r_v0;
  logic [31:0]    r_v1;

  logic           w_acc;
  logic           w_key_last;
  logic           w_blk_last;
  logic [127:0]   w_key_shadow;
  logic [63:0]    w_blk_shadow;
  logic [63:0]    w_blk_commit;

  assign w_acc = s_valid && r_ready;

  tea_byte_shifter #(.NBYTES(KEY_BYTES)) u_key_shift (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_acc && (r_state == ST_KEY)),
    .i_byte (s_data),
    .o_data (w_key_shadow),
    .o_last (w_key_last)
  );

  tea_byte_shifter #(.NBYTES(BLK_BYTES)) u_blk_shift (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_acc && (r_state == ST_DATA)),
    .i_byte (s_data),
    .o_data (w_blk_shadow),
    .o_last (w_blk_last)
  );

`ifdef TEA_LOADER_CHECKSUM_EN
  logic [7:0] r_csum;

  // Running XOR seeded by the header; the block is complete by CHK.
  always_ff @(posedge clk) begin
    if (w_acc) r_csum <= (r_state == ST_IDLE) ? s_data : (r_csum ^ s_data);
  end

  assign w_blk_commit = w_blk_shadow;
`else
  // Commit happens on the edge that accepts the last block byte, so the
  // byte on the bus is merged with the seven already shifted in.
  assign w_blk_commit = {w_blk_shadow[55:0], s_data};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_start     <= 1'b0;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_is_key    <= 1'b0;
      r_key       <= '0;
      r_v0        <= '0;
      r_v1        <= '0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_acc) begin
            if (s_data == HDR_KEY) begin
              r_is_key <= 1'b1;
              r_state  <= ST_KEY;
            end else if ((s_data == HDR_DATA) && r_key_valid) begin
              r_is_key <= 1'b0;
              r_state  <= ST_DATA;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        ST_KEY: begin
          if (w_acc && w_key_last) r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (w_acc && w_blk_last) begin
`ifdef TEA_LOADER_CHECKSUM_EN
            r_state <= ST_CHK;
`else
            r_v0    <= w_blk_commit[63:32];
            r_v1    <= w_blk_commit[31:0];
            if (r_is_key) begin
              r_key       <= w_key_shadow;
              r_key_valid <= 1'b1;
            end
            r_start <= 1'b1;
            r_ready <= 1'b0;
            r_state <= ST_LAUNCH;
`endif
          end
        end
`ifdef TEA_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (w_acc) begin
            if (s_data == r_csum) begin
              r_v0    <= w_blk_commit[63:32];
              r_v1    <= w_blk_commit[31:0];
              if (r_is_key) begin
                r_key       <= w_key_shadow;
                r_key_valid <= 1'b1;
              end
              r_start <= 1'b1;
              r_ready <= 1'b0;
              r_state <= ST_LAUNCH;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
        end
`endif
        ST_LAUNCH: begin
          // s_ready reopens together with start falling.
          if (enc_done) begin
            r_start <= 1'b0;
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready   = r_ready;
  assign key       = r_key;
  assign v0        = r_v0;
  assign v1        = r_v1;
  assign start     = r_start;
  assign key_valid = r_key_valid;
  assign frame_err = r_frame_err;

endmodule
